// File: rtl/vmicro16_cluster_apb_ic_pkg.sv
// rtl/vmicro16_cluster_apb_ic_pkg.sv - shared constants for the cluster APB interconnect
// Purpose : FSM state encodings and default routing/timeout constants used by
//           vmicro16_cluster_apb_ic and its local memory.
// Contents: IC_* state codes, DEF_LOCAL_SEL_BIT, DEF_TIMEOUT_CYCLES, ERR_COUNT_MAX.
package vmicro16_cluster_apb_ic_pkg;

  localparam logic [1:0] IC_IDLE   = 2'd0;
  localparam logic [1:0] IC_SETUP  = 2'd1;
  localparam logic [1:0] IC_ACCESS = 2'd2;
  localparam logic [1:0] IC_DONE   = 2'd3;

  localparam int DEF_LOCAL_SEL_BIT  = 15;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/vmicro16_cluster_lmem.sv
// rtl/vmicro16_cluster_lmem.sv - cluster-local single-port synchronous word memory
// Purpose : LOCAL_WORDS x DATA_WIDTH RAM; a read during a write returns the old word.
//           Contents are deliberately not reset.
// Ports   : clk, i_en (access enable), i_we (write), i_addr, i_wdata, o_rdata (registered).
module vmicro16_cluster_lmem #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOCAL_WORDS = 64,
  parameter int ADDR_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [LOCAL_WORDS];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/vmicro16_cluster_apb_ic.sv
// rtl/vmicro16_cluster_apb_ic.sv - round-robin APB interconnect: NCORES cores to local RAM or upstream
// Purpose : Arbitrates one transfer at a time among the core ports. Address bit
//           LOCAL_SEL_BIT picks the local RAM (0) or the upstream master (1).
//           Upstream accesses abort with PSLVERR after TIMEOUT_CYCLES wait cycles.
// Ports   : clk, reset (async, active low)
//           S_*  : packed per-core APB slave ports (core c in slice c)
//           M_*  : upstream APB master port
//           grant_id : core currently or last granted; err_count : saturating timeout count
module vmicro16_cluster_apb_ic
  import vmicro16_cluster_apb_ic_pkg::*;
#(
  parameter int BUS_WIDTH      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int NCORES         = 4,
  parameter int LOCAL_WORDS    = 64,
  parameter int LOCAL_SEL_BIT  = DEF_LOCAL_SEL_BIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int GW            = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCORES*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [NCORES-1:0]            S_PWRITE,
  input  logic [NCORES-1:0]            S_PSELx,
  input  logic [NCORES-1:0]            S_PENABLE,
  input  logic [NCORES*DATA_WIDTH-1:0] S_PWDATA,
  output logic [NCORES*DATA_WIDTH-1:0] S_PRDATA,
  output logic [NCORES-1:0]            S_PREADY,
  output logic [NCORES-1:0]            S_PSLVERR,
  output logic [BUS_WIDTH-1:0]         M_PADDR,
  output logic                         M_PWRITE,
  output logic                         M_PSELx,
  output logic                         M_PENABLE,
  output logic [DATA_WIDTH-1:0]        M_PWDATA,
  input  logic [DATA_WIDTH-1:0]        M_PRDATA,
  input  logic                         M_PREADY,
  output logic [GW-1:0]                grant_id,
  output logic [7:0]                   err_count
);

  localparam int LAW = (LOCAL_WORDS > 1) ? $clog2(LOCAL_WORDS) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SPW = NCORES * DATA_WIDTH;

  logic [1:0]            r_state;
  logic [GW-1:0]         r_ptr;
  logic [GW-1:0]         r_grant;
  logic [BUS_WIDTH-1:0]  r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_up;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [TW-1:0]         r_tcnt;
  logic [7:0]            r_err_count;

  // First requester at or after ptr, wrapping modulo NCORES.
  function automatic logic [GW-1:0] rr_pick(input logic [NCORES-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0]     pick;
    logic              found;
    logic [NCORES-1:0] sh;
    int                idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      idx = (int'(ptr) + i) % NCORES;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [GW-1:0]               w_pick;
  logic [NCORES*BUS_WIDTH-1:0] w_addr_sh;
  logic [SPW-1:0]              w_wdata_sh;
  logic [NCORES-1:0]           w_write_sh;
  logic [NCORES-1:0]           w_pen_sh;
  logic [BUS_WIDTH-1:0]        w_req_addr;
  logic [DATA_WIDTH-1:0]       w_req_wdata;
  logic                        w_req_write;
  logic                        w_pen;
  logic                        w_timeout;
  logic                        w_done;
  logic                        w_up_active;
  logic [DATA_WIDTH-1:0]       w_mem_rdata;
  logic [DATA_WIDTH-1:0]       w_done_data;
  logic [NCORES-1:0]           w_grant_oh;
  logic [GW-1:0]               w_ptr_next;

  assign w_pick      = rr_pick(S_PSELx, r_ptr);
  assign w_addr_sh   = S_PADDR >> (w_pick * BUS_WIDTH);
  assign w_wdata_sh  = S_PWDATA >> (w_pick * DATA_WIDTH);
  assign w_write_sh  = S_PWRITE >> w_pick;
  assign w_pen_sh    = S_PENABLE >> r_grant;
  assign w_req_addr  = w_addr_sh[BUS_WIDTH-1:0];
  assign w_req_wdata = w_wdata_sh[DATA_WIDTH-1:0];
  assign w_req_write = w_write_sh[0];
  assign w_pen       = w_pen_sh[0];

  // Fires on the last permitted ACCESS cycle; a zero limit never fires.
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_ptr_next  = (r_grant == GW'(NCORES - 1)) ? '0 : r_grant + 1'b1;

  assign w_done      = (r_state == IC_DONE);
  assign w_up_active = r_up && ((r_state == IC_SETUP) || (r_state == IC_ACCESS));
  assign w_done_data = r_up ? r_rdata : w_mem_rdata;
  assign w_grant_oh  = NCORES'(1) << r_grant;

  // Outputs decode straight from registered state so an async reset idles them at once.
  assign S_PREADY    = w_done ? w_grant_oh : '0;
  assign S_PSLVERR   = (w_done && r_err) ? w_grant_oh : '0;
  assign S_PRDATA    = w_done ? (SPW'(w_done_data) << (r_grant * DATA_WIDTH)) : '0;

  assign M_PSELx     = w_up_active;
  assign M_PENABLE   = r_up && (r_state == IC_ACCESS);
  assign M_PADDR     = w_up_active ? r_addr : '0;
  assign M_PWRITE    = w_up_active ? r_write : 1'b0;
  assign M_PWDATA    = w_up_active ? r_wdata : '0;

  assign grant_id    = r_grant;
  assign err_count   = r_err_count;

  vmicro16_cluster_lmem #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOCAL_WORDS(LOCAL_WORDS),
    .ADDR_BITS  (LAW)
  ) u_lmem (
    .clk    (clk),
    .i_en   ((r_state == IC_ACCESS) && !r_up),
    .i_we   (r_write),
    .i_addr (r_addr[LAW-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IC_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_up        <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_tcnt      <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        IC_IDLE: begin
          if (|S_PSELx) begin
            r_grant <= w_pick;
            r_addr  <= w_req_addr;
            r_write <= w_req_write;
            r_wdata <= w_req_wdata;
            r_up    <= w_req_addr[LOCAL_SEL_BIT];
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
            r_state <= IC_SETUP;
          end
        end
        IC_SETUP: begin
          if (w_pen) begin
            r_state <= IC_ACCESS;
          end
        end
        IC_ACCESS: begin
          if (!r_up) begin
            r_state <= IC_DONE;
          end else if (M_PREADY) begin
            r_rdata <= M_PRDATA;
            r_err   <= 1'b0;
            r_state <= IC_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            if (r_err_count != ERR_COUNT_MAX) begin
              r_err_count <= r_err_count + 8'd1;
            end
            r_state <= IC_DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        IC_DONE: begin
          r_ptr   <= w_ptr_next;
          r_state <= IC_IDLE;
        end
        default: r_state <= IC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_cluster_apb_ic.sv
// tb/tb_vmicro16_cluster_apb_ic.sv - directed self-checking bench for vmicro16_cluster_apb_ic
module tb_vmicro16_cluster_apb_ic;

  localparam int NC = 4;
  localparam int BW = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*BW-1:0] S_PADDR;
  logic [NC-1:0]    S_PWRITE;
  logic [NC-1:0]    S_PSELx;
  logic [NC-1:0]    S_PENABLE;
  logic [NC*DW-1:0] S_PWDATA;
  logic [NC*DW-1:0] S_PRDATA;
  logic [NC-1:0]    S_PREADY;
  logic [NC-1:0]    S_PSLVERR;
  logic [BW-1:0]    M_PADDR;
  logic             M_PWRITE;
  logic             M_PSELx;
  logic             M_PENABLE;
  logic [DW-1:0]    M_PWDATA;
  logic [DW-1:0]    M_PRDATA;
  logic             M_PREADY;
  logic [1:0]       grant_id;
  logic [7:0]       err_count;

  always #5 clk = ~clk;

  vmicro16_cluster_apb_ic #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .NCORES(NC), .LOCAL_WORDS(64),
    .LOCAL_SEL_BIT(15), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant_id(grant_id), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Upstream slave: ready on access cycle slave_wait+1; negative means never ready.
  int          slave_wait = 0;
  int          acc_cnt    = 0;
  int          acc_peak   = 0;
  logic        m_seen     = 1'b0;
  logic [15:0] up_addr    = '0;
  logic        up_write   = 1'b0;

  initial begin
    M_PREADY = 1'b0;
    M_PRDATA = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (M_PSELx) m_seen = 1'b1;
      if (M_PSELx && M_PENABLE) begin
        acc_cnt++;
        if (acc_cnt == 1) begin
          up_addr  = M_PADDR;
          up_write = M_PWRITE;
        end
        if (acc_cnt > acc_peak) acc_peak = acc_cnt;
      end else begin
        acc_cnt = 0;
      end
      M_PREADY = (slave_wait >= 0) && (acc_cnt == slave_wait + 1);
    end
  end

  // One APB transfer from core c; lat counts negedges after the IDLE sampling edge.
  task automatic xfer(input int c, input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                      output logic [15:0] rd, output logic er, output int lat);
    @(negedge clk);
    S_PADDR[c*BW +: BW]  = addr;
    S_PWRITE[c]          = wr;
    S_PWDATA[c*DW +: DW] = wd;
    S_PSELx[c]           = 1'b1;
    @(posedge clk);
    #1 S_PENABLE[c] = 1'b1;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (S_PREADY[c]) break;
    end
    rd = S_PRDATA[c*DW +: DW];
    er = S_PSLVERR[c];
    S_PSELx[c]   = 1'b0;
    S_PENABLE[c] = 1'b0;
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  int          exp_order [5] = '{0, 1, 2, 3, 0};
  int          n;
  int          idx;
  logic        pend0;

  initial begin
    reset     = 1'b0;
    S_PADDR   = '0;
    S_PWRITE  = '0;
    S_PSELx   = '0;
    S_PENABLE = '0;
    S_PWDATA  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_pready", S_PREADY, 0);
    check("rst_s_prdata", S_PRDATA, 0);
    check("rst_m_pselx", M_PSELx, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b1;

    // Local write then read on core 0
    m_seen = 1'b0;
    xfer(0, 16'h0005, 1'b1, 16'h1234, rd, er, lat);
    check("lw_latency", lat, 3);
    check("lw_err", er, 0);
    xfer(0, 16'h0005, 1'b0, 16'h0000, rd, er, lat);
    check("lr_latency", lat, 3);
    check("lr_data", rd, 16'h1234);
    check("local_no_m_psel", m_seen, 0);

    // Upstream read, two wait states
    slave_wait = 2;
    acc_peak   = 0;
    xfer(1, 16'h8010, 1'b0, 16'h0000, rd, er, lat);
    check("up_data", rd, 16'hBEEF);
    check("up_err", er, 0);
    check("up_addr", up_addr, 16'h8010);
    check("up_write", up_write, 0);
    check("up_access_cycles", acc_peak, 3);
    check("up_latency", lat, 5);
    check("up_grant_id", grant_id, 1);

    // Preload words for contention reads; leaves pointer back at core 0
    for (int c = 0; c < NC; c++) begin
      xfer(c, 16'h000A + 16'(c), 1'b1, 16'h1100 + 16'(c), rd, er, lat);
    end

    // Contention: all four cores at once, core 0 re-requests right after its grant
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      S_PADDR[c*BW +: BW] = 16'h000A + 16'(c);
      S_PWRITE[c]         = 1'b0;
      S_PSELx[c]          = 1'b1;
    end
    @(posedge clk);
    #1 S_PENABLE = '1;
    n     = 0;
    pend0 = 1'b0;
    for (int cyc = 0; cyc < 80 && n < 5; cyc++) begin
      @(negedge clk);
      if (pend0) begin
        S_PENABLE[0] = 1'b1;
        pend0        = 1'b0;
      end
      if (|S_PREADY) begin
        idx = -1;
        for (int k = 0; k < NC; k++) if (S_PREADY[k]) idx = k;
        check("rr_onehot", $countones(S_PREADY), 1);
        check("rr_order", idx, exp_order[n]);
        check("rr_data", S_PRDATA[idx*DW +: DW], 16'h1100 + 16'(idx));
        if (n == 0 && idx == 0) begin
          S_PENABLE[0] = 1'b0;
          pend0        = 1'b1;
        end else begin
          S_PSELx[idx]   = 1'b0;
          S_PENABLE[idx] = 1'b0;
        end
        n++;
      end
    end
    check("rr_count", n, 5);
    S_PSELx   = '0;
    S_PENABLE = '0;

    // Local aliasing: upper address bits ignored
    xfer(2, 16'h0041, 1'b1, 16'hA5A5, rd, er, lat);
    xfer(2, 16'h0001, 1'b0, 16'h0000, rd, er, lat);
    check("alias_data", rd, 16'hA5A5);

    // Upstream timeout
    slave_wait = -1;
    acc_peak   = 0;
    xfer(3, 16'h8020, 1'b0, 16'h0000, rd, er, lat);
    check("to_err", er, 1);
    check("to_data", rd, 0);
    check("to_access_cycles", acc_peak, 4);
    check("to_latency", lat, 6);
    check("to_m_psel_dropped", M_PSELx, 0);
    check("to_err_count1", err_count, 1);
    for (int r = 1; r < 300; r++) begin
      xfer(3, 16'h8020, 1'b0, 16'h0000, rd, er, lat);
    end
    check("to_err_count_sat", err_count, 8'hFF);

    // Reset during an upstream ACCESS
    @(negedge clk);
    S_PADDR[2*BW +: BW] = 16'h8030;
    S_PWRITE[2]         = 1'b0;
    S_PSELx[2]          = 1'b1;
    @(posedge clk);
    #1 S_PENABLE[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_access", M_PENABLE, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_m_pselx", M_PSELx, 0);
    check("mid_m_penable", M_PENABLE, 0);
    check("mid_s_pready", S_PREADY, 0);
    check("mid_err_count", err_count, 0);
    S_PSELx   = '0;
    S_PENABLE = '0;
    repeat (2) begin
      @(negedge clk);
      check("mid_no_pready", S_PREADY, 0);
    end
    reset      = 1'b1;
    slave_wait = 0;
    xfer(2, 16'h8040, 1'b0, 16'h0000, rd, er, lat);
    check("post_rst_data", rd, 16'hBEEF);
    check("post_rst_err", er, 0);
    check("post_rst_latency", lat, 3);
    check("post_rst_grant", grant_id, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
